select_encode_regfile: RTL and testbench

SELECT_ENCODE_REGFILE -- requirements
Module: select_encode_regfile

---
 rtl/select_encode_regfile_pkg.sv | 21 ++
 rtl/select_encode_regfile_decoder_4to16.sv | 12 +
 rtl/select_encode_regfile.sv | 117 +++++++++++
 tb/tb_select_encode_regfile.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/select_encode_regfile_pkg.sv
// Shared definitions for the select/encode register file: IR field positions,
// default sizes and the sweep FSM state type.
package select_encode_regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 16;

    localparam int IR_RA_MSB = 26;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_MSB = 22;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_MSB = 18;
    localparam int IR_RC_LSB = 15;
    localparam int IR_C_MSB  = 18;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

endpackage

// File: rtl/select_encode_regfile_decoder_4to16.sv
// Combinational 4-to-16 one-hot decoder driving the register enables.
module decoder_4to16 (
    input  logic [3:0]  sel_i,
    output logic [15:0] dec_o
);

    always_comb begin
        dec_o        = '0;
        dec_o[sel_i] = 1'b1;
    end

endmodule

// File: rtl/select_encode_regfile.sv
// Register file with IR field select/encode logic and a 16-cycle clearing sweep.
// Optional sticky write-error flag enabled by defining SER_WR_ERR_EN.
module select_encode_regfile
    import select_encode_regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic                       clock,
    input  logic                       clear,
    input  logic [31:0]                ir,
    input  logic                       gra,
    input  logic                       grb,
    input  logic                       grc,
    input  logic                       rin,
    input  logic                       rout,
    input  logic                       baout,
    input  logic [DATA_W-1:0]          bus_in,
    input  logic                       sweep_req,
    output logic                       sweep_busy,
    output logic [15:0]                reg_out_en,
    output logic [NUM_REGS*DATA_W-1:0] r_q,
    output logic [31:0]                c_sign_ext,
    output logic                       wr_err
);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [3:0]        sel;
    logic [15:0]       dec;
    logic              wr_en;
    logic              unused_ir_hi;

    assign unused_ir_hi = ^ir[31:27];

    // Overlapping field selects OR together bitwise.
    assign sel = (ir[IR_RA_MSB:IR_RA_LSB] & {4{gra}})
               | (ir[IR_RB_MSB:IR_RB_LSB] & {4{grb}})
               | (ir[IR_RC_MSB:IR_RC_LSB] & {4{grc}});

    decoder_4to16 u_dec (
        .sel_i (sel),
        .dec_o (dec)
    );

    assign reg_out_en = (rout || baout) ? dec : 16'h0000;
    assign c_sign_ext = {{(31 - IR_C_MSB){ir[IR_C_MSB]}}, ir[IR_C_MSB:0]};
    assign wr_en      = rin && (state_q == IDLE);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sweep_busy = 1'b0;
        case (state_q)
            IDLE: begin
                if (sweep_req) begin
                    state_d = SWEEP;
                    cnt_d   = 4'd0;
                end
            end
            SWEEP: begin
                sweep_busy = 1'b1;
                cnt_d      = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == SWEEP) begin
                regs_q[cnt_q] <= '0;
            end else if (wr_en) begin
                regs_q[sel] <= bus_in;
            end
        end
    end

    // R0 reads as zero while the base-address path is active.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            r_q[i*DATA_W +: DATA_W] = regs_q[i];
        end
        if (baout) begin
            r_q[DATA_W-1:0] = '0;
        end
    end

`ifdef SER_WR_ERR_EN
    logic wr_err_q;

    always_ff @(posedge clock) begin
        if (clear) begin
            wr_err_q <= 1'b0;
        end else if (rin && ((state_q == SWEEP) || !(gra || grb || grc))) begin
            wr_err_q <= 1'b1;
        end
    end

    assign wr_err = wr_err_q;
`else
    assign wr_err = 1'b0;
`endif

endmodule

// File: tb/tb_select_encode_regfile.sv
// Randomized and directed self-checking bench for select_encode_regfile,
// compared against an array-based behavioural model of the register file.
module tb_select_encode_regfile;

    logic         clock = 1'b0;
    logic         clear, gra, grb, grc, rin, rout, baout, sweep_req;
    logic [31:0]  ir, bus_in;
    logic         sweep_busy, wr_err;
    logic [15:0]  reg_out_en;
    logic [511:0] r_q;
    logic [31:0]  c_sign_ext;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [16];
    int          m_pos;
    logic        m_err;

    select_encode_regfile dut (
        .clock      (clock),
        .clear      (clear),
        .ir         (ir),
        .gra        (gra),
        .grb        (grb),
        .grc        (grc),
        .rin        (rin),
        .rout       (rout),
        .baout      (baout),
        .bus_in     (bus_in),
        .sweep_req  (sweep_req),
        .sweep_busy (sweep_busy),
        .reg_out_en (reg_out_en),
        .r_q        (r_q),
        .c_sign_ext (c_sign_ext),
        .wr_err     (wr_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] exp_rq(input logic ba);
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = m_regs[i];
        if (ba) v[31:0] = 32'h0;
        return v;
    endfunction

    function automatic int model_sel();
        int ra, rb, rc;
        ra = gra ? int'((ir >> 23) & 32'hF) : 0;
        rb = grb ? int'((ir >> 19) & 32'hF) : 0;
        rc = grc ? int'((ir >> 15) & 32'hF) : 0;
        return ra | rb | rc;
    endfunction

    task automatic drive(input logic [31:0] ir_v, input logic a, input logic b, input logic c,
                         input logic ri, input logic ro, input logic ba, input logic [31:0] bus,
                         input logic sw, input logic clr);
        ir = ir_v; gra = a; grb = b; grc = c; rin = ri; rout = ro; baout = ba;
        bus_in = bus; sweep_req = sw; clear = clr;
    endtask

    task automatic idle();
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // One clock: check combinational outputs, advance the model at the edge,
    // then check the registered state.
    task automatic tick();
        int          s;
        logic [31:0] ce;
        #1;
        s  = model_sel();
        chk("reg_out_en", reg_out_en, (rout || baout) ? (16'h1 << s) : 16'h0);
        chk("r_q_pre", r_q, exp_rq(baout));
        ce = {13'h0, ir[18:0]};
        if (ir[18]) ce = ce - 32'h0008_0000;
        chk("c_sign_ext", c_sign_ext, ce);
        @(posedge clock);
        if (clear) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
            m_pos = -1;
            m_err = 1'b0;
        end else if (m_pos >= 0) begin
            if (rin) m_err = 1'b1;
            m_regs[m_pos] = 32'h0;
            m_pos = (m_pos == 15) ? -1 : m_pos + 1;
        end else begin
            if (rin) begin
                m_regs[s] = bus_in;
                if (!gra && !grb && !grc) m_err = 1'b1;
            end
            if (sweep_req) m_pos = 0;
        end
        #1;
        chk("r_q", r_q, exp_rq(baout));
        chk("sweep_busy", sweep_busy, m_pos >= 0);
`ifdef SER_WR_ERR_EN
        chk("wr_err", wr_err, m_err);
`else
        chk("wr_err", wr_err, 1'b0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
        m_pos = -1;
        m_err = 1'b0;

        // Reset
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        tick();
        chk("rst_rq", r_q, 512'h0);
        chk("rst_busy", sweep_busy, 1'b0);
        chk("rst_err", wr_err, 1'b0);

        // Ra=5 write
        drive(32'd5 << 23, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
        tick();
        chk("r5_write", r_q, 512'hDEADBEEF << 160);

        // R0 base-address masking
        drive(32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1234, 1'b0, 1'b0);
        tick();
        drive(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        #1;
        chk("ba_en", reg_out_en, 16'h0001);
        chk("ba_r0", r_q[31:0], 32'h0);
        tick();
        drive(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("rout_en", reg_out_en, 16'h0001);
        chk("rout_r0", r_q[31:0], 32'h1234);
        tick();

        // Full sweep after loading every register
        for (int i = 0; i < 16; i++) begin
            drive(32'(i) << 23, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1000 + 32'(i) + 1, 1'b0, 1'b0);
            tick();
        end
        drive(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        idle();
        n = 0;
        while (sweep_busy && n < 40) begin
            n++;
            tick();
        end
        chk("sweep_len", n, 16);
        chk("sweep_zero", r_q, 512'h0);
        chk("sweep_idle", sweep_busy, 1'b0);

        // Write attempt into R3 during sweep cycle 4
        drive(32'd3 << 19, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h3333, 1'b0, 1'b0);
        tick();
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        idle();
        for (int i = 0; i < 4; i++) tick();
        drive(32'd3 << 19, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hBAD0BAD0, 1'b0, 1'b0);
        tick();
        chk("r3_blocked", r_q[3*32 +: 32], 32'h0);
`ifdef SER_WR_ERR_EN
        chk("sweep_wr_err", wr_err, 1'b1);
`else
        chk("sweep_wr_err", wr_err, 1'b0);
`endif
        idle();
        n = 0;
        while (sweep_busy && n < 40) begin
            n++;
            tick();
        end
        chk("sweep2_done", sweep_busy, 1'b0);

        // Clear aborts sweep at cycle 7
        drive(32'd10 << 23, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA, 1'b0, 1'b0);
        tick();
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        idle();
        for (int i = 0; i < 7; i++) tick();
        chk("r10_held", r_q[10*32 +: 32], 32'hA);
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        chk("abort_rq", r_q, 512'h0);
        chk("abort_busy", sweep_busy, 1'b0);
        chk("abort_err", wr_err, 1'b0);

        // Sign extension of the constant field
        drive(32'h0004_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("sext_neg", c_sign_ext, 32'hFFFC0000);
        tick();
        drive(32'h0003_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("sext_pos", c_sign_ext, 32'h0003FFFF);
        tick();

        // Randomized traffic
        for (int k = 0; k < 800; k++) begin
            drive($urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 2) != 0), 1'($urandom), ($urandom_range(0, 3) == 0),
                  $urandom, ($urandom_range(0, 24) == 0), ($urandom_range(0, 120) == 0));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
